// File: rtl/ddr5_dram_wr_receiver.sv
// rtl/ddr5_dram_wr_receiver.sv - DRAM-side write receiver: WR/MRW decode, burst capture, write CRC check
module ddr5_dram_wr_receiver #(
    parameter int pDRAM_SIZE = 4,
    parameter int pNUM_RANK  = 1,
    parameter int pTIMEOUT   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [pNUM_RANK-1:0]    CS_n,
    input  logic [13:0]             CA,
    input  logic [2*pDRAM_SIZE-1:0] DQ,
    input  logic                    DQ_valid,
    input  logic [pDRAM_SIZE/4-1:0] DM,
    output logic [2*pDRAM_SIZE-1:0] wr_data_o,
    output logic [pDRAM_SIZE/4-1:0] wr_mask_o,
    output logic                    wr_valid_o,
    output logic                    burst_done_o,
    output logic                    crc_err_o,
    output logic                    burst_err_o,
    output logic                    cmd_err_o,
    output logic                    mrw_valid_o,
    output logic [7:0]              mr_addr_o,
    output logic [7:0]              mr_op_o,
    output logic                    bl32_o,
    output logic                    crc_en_o
);
    localparam int DW = 2 * pDRAM_SIZE;
    localparam int MW = pDRAM_SIZE / 4;
    localparam int TW = $clog2(pTIMEOUT + 1);

    typedef enum logic {C_IDLE, C_SEC} c_state_t;
    typedef enum logic [1:0] {D_IDLE, D_WAIT, D_DATA, D_CRC} d_state_t;

    // CRC-8 (0x07), data fed MSB first
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [DW-1:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = DW - 1; i >= 0; i--) begin
            if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    c_state_t        c_state_q;
    logic [12:0]     ca1_q;
    logic [7:0]      mr0_q, mr50_q;
    logic            mrw_valid_q, cmd_err_q;
    logic [7:0]      mr_addr_q, mr_op_q;

    logic [1:0]      fifo_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      cnt_q;

    d_state_t        d_state_q;
    logic            cur_bl32_q, cur_crc_q, chunk_q;
    logic [2:0]      beat_q;
    logic [TW-1:0]   tmo_q;
    logic [7:0]      crc_q;
    logic [DW-1:0]   wr_data_q;
    logic [MW-1:0]   wr_mask_q;
    logic            wr_valid_q, done_q, crc_err_q, burst_err_q;

    logic            unused_ca;
    assign unused_ca = CA[13];

    logic cs_any, is_wr, is_mrw, push_req, pop, accept, push_bl32;
    assign cs_any    = ~&CS_n;
    assign is_wr     = (ca1_q[4:0] == 5'b01101);
    assign is_mrw    = (ca1_q[4:0] == 5'b00101);
    assign push_req  = (c_state_q == C_SEC) && is_wr;
    assign pop       = (d_state_q == D_IDLE) && (cnt_q != 2'd0);
    assign accept    = push_req && ((cnt_q != 2'd2) || pop);
    assign push_bl32 = (mr0_q[1:0] == 2'b11) ? ~CA[1] : mr0_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_state_q   <= C_IDLE;
            ca1_q       <= '0;
            mr0_q       <= '0;
            mr50_q      <= '0;
            mrw_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            mr_addr_q   <= '0;
            mr_op_q     <= '0;
        end else begin
            mrw_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            case (c_state_q)
                C_IDLE: begin
                    if (cs_any) begin
                        ca1_q     <= CA[12:0];
                        c_state_q <= C_SEC;
                    end
                end
                C_SEC: begin
                    c_state_q <= C_IDLE;
                    if (is_mrw) begin
                        mrw_valid_q <= 1'b1;
                        mr_addr_q   <= ca1_q[12:5];
                        mr_op_q     <= CA[7:0];
                        if (ca1_q[12:5] == 8'd0)  mr0_q  <= CA[7:0];
                        if (ca1_q[12:5] == 8'd50) mr50_q <= CA[7:0];
                    end
                    if (push_req && !accept) cmd_err_q <= 1'b1;
                end
                default: c_state_q <= C_IDLE;
            endcase
        end
    end

    // Each entry is {bl32, crc_en}, frozen when the WR is decoded
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                fifo_q[wr_ptr_q] <= {push_bl32, mr50_q[1]};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_state_q   <= D_IDLE;
            cur_bl32_q  <= 1'b0;
            cur_crc_q   <= 1'b0;
            chunk_q     <= 1'b0;
            beat_q      <= '0;
            tmo_q       <= '0;
            crc_q       <= '0;
            wr_data_q   <= '0;
            wr_mask_q   <= '0;
            wr_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            burst_err_q <= 1'b0;
        end else begin
            wr_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            burst_err_q <= 1'b0;
            case (d_state_q)
                D_IDLE: begin
                    if (DQ_valid) burst_err_q <= 1'b1;
                    if (pop) begin
                        {cur_bl32_q, cur_crc_q} <= fifo_q[rd_ptr_q];
                        tmo_q     <= '0;
                        d_state_q <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    if (DQ_valid) begin
                        wr_data_q  <= DQ;
                        wr_mask_q  <= DM;
                        wr_valid_q <= 1'b1;
                        crc_q      <= crc8_next(8'h00, DQ);
                        beat_q     <= 3'd1;
                        chunk_q    <= 1'b0;
                        d_state_q  <= D_DATA;
                    end else if (tmo_q == TW'(pTIMEOUT - 1)) begin
                        burst_err_q <= 1'b1;
                        d_state_q   <= D_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                D_DATA: begin
                    if (!DQ_valid) begin
                        burst_err_q <= 1'b1;
                        d_state_q   <= D_IDLE;
                    end else begin
                        wr_data_q  <= DQ;
                        wr_mask_q  <= DM;
                        wr_valid_q <= 1'b1;
                        crc_q      <= crc8_next(crc_q, DQ);
                        beat_q     <= beat_q + 3'd1;
                        if (beat_q == 3'd7) begin
                            if (cur_crc_q) begin
                                d_state_q <= D_CRC;
                            end else if (cur_bl32_q && !chunk_q) begin
                                chunk_q <= 1'b1;
                                crc_q   <= 8'h00;
                            end else begin
                                done_q    <= 1'b1;
                                d_state_q <= D_IDLE;
                            end
                        end
                    end
                end
                D_CRC: begin
                    if (!DQ_valid) begin
                        burst_err_q <= 1'b1;
                        d_state_q   <= D_IDLE;
                    end else begin
                        if (DQ[7:0] != crc_q) crc_err_q <= 1'b1;
                        if (cur_bl32_q && !chunk_q) begin
                            chunk_q   <= 1'b1;
                            crc_q     <= 8'h00;
                            beat_q    <= 3'd0;
                            d_state_q <= D_DATA;
                        end else begin
                            done_q    <= 1'b1;
                            d_state_q <= D_IDLE;
                        end
                    end
                end
                default: d_state_q <= D_IDLE;
            endcase
        end
    end

    assign wr_data_o    = wr_data_q;
    assign wr_mask_o    = wr_mask_q;
    assign wr_valid_o   = wr_valid_q;
    assign burst_done_o = done_q;
    assign crc_err_o    = crc_err_q;
    assign burst_err_o  = burst_err_q;
    assign cmd_err_o    = cmd_err_q;
    assign mrw_valid_o  = mrw_valid_q;
    assign mr_addr_o    = mr_addr_q;
    assign mr_op_o      = mr_op_q;
    assign bl32_o       = mr0_q[1];
    assign crc_en_o     = mr50_q[1];
endmodule

// File: tb/tb_ddr5_dram_wr_receiver.sv
// tb/tb_ddr5_dram_wr_receiver.sv - self-checking bench for ddr5_dram_wr_receiver
module tb_ddr5_dram_wr_receiver;
    localparam int DSZ = 4;
    localparam int DW  = 2 * DSZ;
    localparam int MW  = DSZ / 4;
    localparam int NR  = 1;
    localparam int TMO = 32;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [NR-1:0] CS_n;
    logic [13:0]   CA;
    logic [DW-1:0] DQ;
    logic          DQ_valid;
    logic [MW-1:0] DM;
    logic [DW-1:0] wr_data_o;
    logic [MW-1:0] wr_mask_o;
    logic wr_valid_o, burst_done_o, crc_err_o, burst_err_o, cmd_err_o, mrw_valid_o;
    logic [7:0] mr_addr_o, mr_op_o;
    logic bl32_o, crc_en_o;

    ddr5_dram_wr_receiver #(.pDRAM_SIZE(DSZ), .pNUM_RANK(NR), .pTIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .CS_n(CS_n), .CA(CA), .DQ(DQ), .DQ_valid(DQ_valid), .DM(DM),
        .wr_data_o(wr_data_o), .wr_mask_o(wr_mask_o), .wr_valid_o(wr_valid_o),
        .burst_done_o(burst_done_o), .crc_err_o(crc_err_o), .burst_err_o(burst_err_o),
        .cmd_err_o(cmd_err_o), .mrw_valid_o(mrw_valid_o), .mr_addr_o(mr_addr_o),
        .mr_op_o(mr_op_o), .bl32_o(bl32_o), .crc_en_o(crc_en_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int c_wr, c_done, c_crc, c_berr, c_cerr, c_mrw;
    logic [DW+MW-1:0] got_q [$];

    // Mode-register model
    logic m_bl32, m_otf, m_crc;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (wr_valid_o) begin
                c_wr++;
                got_q.push_back({wr_mask_o, wr_data_o});
            end
            if (burst_done_o) c_done++;
            if (crc_err_o)    c_crc++;
            if (burst_err_o)  c_berr++;
            if (cmd_err_o)    c_cerr++;
            if (mrw_valid_o)  c_mrw++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // CRC as remainder of M(x)*x^8 divided by x^8+x^2+x+1
    function automatic logic [7:0] crc_ref(input logic [63:0] msg);
        logic [71:0] r;
        r = {msg, 8'h00};
        for (int i = 71; i >= 8; i--)
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        return r[7:0];
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_counts();
        c_wr = 0; c_done = 0; c_crc = 0; c_berr = 0; c_cerr = 0; c_mrw = 0;
        got_q.delete();
    endtask

    task automatic cmd(input logic [13:0] a, input logic [13:0] b);
        CS_n = '0; CA = a;
        step();
        CS_n = '1; CA = b;
        step();
        CA = '0;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic mrw(input logic [7:0] addr, input logic [7:0] op);
        clear_counts();
        cmd({1'b0, addr, 5'b00101}, {6'b0, op});
        if (addr == 8'd0) begin
            m_bl32 = op[1];
            m_otf  = (op[1:0] == 2'b11);
        end
        if (addr == 8'd50) m_crc = op[1];
        n_cmp++;
        if ({mrw_valid_o, mr_addr_o, mr_op_o, bl32_o, crc_en_o} !== {1'b1, addr, op, m_bl32, m_crc}) begin
            n_bad++;
            $display("FAIL mrw_regs: got v=%0b a=%h o=%h bl32=%0b crc=%0b want v=1 a=%h o=%h bl32=%0b crc=%0b",
                     mrw_valid_o, mr_addr_o, mr_op_o, bl32_o, crc_en_o, addr, op, m_bl32, m_crc);
        end
        step(); step();
        check_int("mrw_pulse_count", c_mrw, 1);
    endtask

    task automatic run_wr(input logic [13:0] ca2, input int fixed, input bit corrupt, input string name);
        logic bl32;
        int nchunk, exp_crc_err;
        logic [63:0] msg;
        logic [7:0] d;
        logic [MW-1:0] m;
        logic [DW+MW-1:0] exp_q [$];
        bl32 = m_otf ? ~ca2[1] : m_bl32;
        nchunk = bl32 ? 2 : 1;
        exp_crc_err = (m_crc && corrupt) ? nchunk : 0;
        clear_counts();
        cmd(14'h000D, ca2);
        step();
        repeat ($urandom_range(0, 3)) step();
        for (int ch = 0; ch < nchunk; ch++) begin
            msg = '0;
            for (int k = 0; k < 8; k++) begin
                d = (fixed >= 0) ? fixed[7:0] : 8'($urandom);
                m = MW'($urandom);
                DQ = d; DM = m; DQ_valid = 1'b1;
                msg = {msg[55:0], d};
                exp_q.push_back({m, d});
                step();
            end
            if (m_crc) begin
                DQ = crc_ref(msg) ^ {7'b0, corrupt};
                DM = '0;
                step();
            end
        end
        DQ_valid = 1'b0; DQ = '0; DM = '0;
        repeat (4) step();
        check_int({name, "_wr_valid_count"}, c_wr, exp_q.size());
        check_int({name, "_burst_done"}, c_done, 1);
        check_int({name, "_crc_err"}, c_crc, exp_crc_err);
        check_int({name, "_burst_err"}, c_berr + c_cerr, 0);
        n_cmp++;
        begin
            int bad_idx;
            bad_idx = -1;
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                if (bad_idx < 0 && got_q[i] !== exp_q[i]) bad_idx = i;
            if (bad_idx >= 0) begin
                n_bad++;
                $display("FAIL %s_data[%0d]: got %h want %h", name, bad_idx, got_q[bad_idx], exp_q[bad_idx]);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; CS_n = '1; CA = '0; DQ = '0; DQ_valid = 1'b0; DM = '0;
        m_bl32 = 1'b0; m_otf = 1'b0; m_crc = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({wr_data_o, wr_mask_o, wr_valid_o, burst_done_o, crc_err_o, burst_err_o, cmd_err_o,
             mrw_valid_o, mr_addr_o, mr_op_o, bl32_o, crc_en_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got data=%h bl32=%0b crc=%0b want all zero", wr_data_o, bl32_o, crc_en_o);
        end
        rst_i = 1'b0;
        step();
        check_int("post_reset_idle_pulses", int'({wr_valid_o, burst_done_o, burst_err_o, cmd_err_o}), 0);
    endtask

    task automatic test_bl16_nocrc();
        for (int i = 0; i < 3; i++) run_wr(14'h0000, -1, 1'b0, "bl16");
    endtask

    task automatic test_mrw_bl32();
        mrw(8'h00, 8'h02);
        run_wr(14'h0000, 8'hAA, 1'b0, "bl32_aa");
        run_wr(14'h0000, -1, 1'b0, "bl32_rand");
        mrw(8'h00, 8'h00);
        mrw(8'h17, 8'h5A);
    endtask

    task automatic test_crc();
        mrw(8'd50, 8'h06);
        run_wr(14'h0000, 8'hCB, 1'b0, "crc_good");
        run_wr(14'h0000, 8'hCB, 1'b1, "crc_bad");
        for (int i = 0; i < 2; i++) run_wr(14'h0000, -1, 1'(i), "crc_rand");
    endtask

    task automatic test_otf();
        mrw(8'h00, 8'h03);
        run_wr(14'h001C, -1, 1'b0, "otf_bl32");
        run_wr(14'h0002, -1, 1'b0, "otf_bl16");
    endtask

    task automatic test_queue();
        int t;
        clear_counts();
        for (int i = 0; i < 4; i++) cmd(14'h000D, 14'h0002);
        t = 0;
        while (c_berr < 3 && t < 200) begin step(); t++; end
        repeat (3) step();
        check_int("queue_cmd_err", c_cerr, 1);
        check_int("queue_timeouts", c_berr, 3);
        check_int("queue_no_done", c_done + c_wr, 0);
        clear_counts();
        cmd(14'h000D, 14'h0002);
        t = 0;
        while (c_berr == 0 && t < 100) begin step(); t++; end
        n_cmp++;
        if (t < TMO || t > TMO + 4) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d clocks want %0d..%0d", t, TMO, TMO + 4);
        end
    endtask

    task automatic test_gap_stray();
        clear_counts();
        cmd(14'h000D, 14'h0002);
        step();
        for (int k = 0; k < 4; k++) begin
            DQ = 8'($urandom); DQ_valid = 1'b1;
            step();
        end
        DQ_valid = 1'b0;
        repeat (4) step();
        check_int("gap_burst_err", c_berr, 1);
        check_int("gap_no_done", c_done, 0);
        check_int("gap_wr_valid", c_wr, 4);
        clear_counts();
        DQ = 8'($urandom); DQ_valid = 1'b1;
        step();
        DQ_valid = 1'b0;
        repeat (3) step();
        check_int("stray_burst_err", c_berr, 1);
        check_int("stray_no_data", c_wr + c_done, 0);
    endtask

    task automatic test_reset_mid();
        cmd(14'h000D, 14'h0002);
        step();
        for (int k = 0; k < 3; k++) begin
            DQ = 8'($urandom); DQ_valid = 1'b1;
            step();
        end
        rst_i = 1'b1;
        step();
        n_cmp++;
        if ({wr_data_o, wr_mask_o, wr_valid_o, burst_done_o, crc_err_o, burst_err_o, cmd_err_o,
             mrw_valid_o, mr_addr_o, mr_op_o, bl32_o, crc_en_o} !== '0) begin
            n_bad++;
            $display("FAIL midburst_reset_outputs: got valid=%0b crc_en=%0b mr_op=%h want all zero",
                     wr_valid_o, crc_en_o, mr_op_o);
        end
        m_bl32 = 1'b0; m_otf = 1'b0; m_crc = 1'b0;
        rst_i = 1'b0; DQ_valid = 1'b0;
        clear_counts();
        repeat (5) step();
        check_int("midburst_no_pulses", c_done + c_berr + c_crc + c_wr, 0);
        run_wr(14'h0000, -1, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_bl16_nocrc();
        test_mrw_bl32();
        test_crc();
        test_otf();
        test_queue();
        test_gap_stray();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
